// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_t;

    // True when the access cannot be served by a single aligned word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the core-side request/response signals and the word-memory port.
// slave is the load/store unit's view, master is the core + memory side.
interface lsu_if;
    logic        req;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req, st, size, uns, addr, wdata, mem_rd,
        output busy, done, err, rdata, mem_a, mem_wd, mem_we
    );

    modport master (
        output req, st, size, uns, addr, wdata, mem_rd,
        input  busy, done, err, rdata, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/lane_align.sv
// Little-endian lane handling shared by the load path (extract + extend) and
// the read-modify-write path (insert into the fetched word).
module lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] data,
    output logic [31:0] ext_value,
    output logic [31:0] merged
);

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] ofs,
                                            input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (ofs)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = ofs[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = {{24{b[7] & ~u}}, b};
            SZ_HALF: r = {{16{h[15] & ~u}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] insert(input logic [31:0] w, input logic [1:0] ofs,
                                           input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        m = w;
        case (sz)
            SZ_BYTE: begin
                case (ofs)
                    2'd0:    m[7:0]   = d[7:0];
                    2'd1:    m[15:8]  = d[7:0];
                    2'd2:    m[23:16] = d[7:0];
                    default: m[31:24] = d[7:0];
                endcase
            end
            SZ_HALF: begin
                if (ofs[1]) m[31:16] = d[15:0];
                else        m[15:0]  = d[15:0];
            end
            default: m = d;
        endcase
        return m;
    endfunction

    assign ext_value = extract(word, offset, size, uns);
    assign merged    = insert(word, offset, size, data);

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word loads and stores into aligned word-only memory
// accesses; sub-word stores go through a read-modify-write of the word.
//
//   state  | meaning
//   IDLE   | waiting for req; request fields captured on acceptance
//   LOAD   | word addressed, lane extracted into rdata at the edge
//   RMW_RD | word addressed, target lane merged into mem_wd at the edge
//   WRITE  | mem_we high, memory commits mem_wd at the edge
//   RESP   | done pulse, err qualifies misaligned/illegal requests
module load_store_unit
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_t  state;
    lsu_state_t  state_nxt;

    logic        st_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_wd_q;

    logic        accept;
    logic        bad_req;
    logic [31:0] lane_value;
    logic [31:0] lane_merged;

    assign accept  = (state == IDLE) && bus.req;
    assign bad_req = misaligned(bus.size, bus.addr[1:0]);

    lane_align u_lane_align (
        .word      (bus.mem_rd),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .uns       (uns_q),
        .data      (wdata_q),
        .ext_value (lane_value),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bad_req)              state_nxt = RESP;
                    else if (!bus.st)         state_nxt = LOAD;
                    else if (bus.size == SZ_WORD) state_nxt = WRITE;
                    else                      state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            RMW_RD:  state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            mem_wd_q <= 32'd0;
        end else begin
            if (accept) begin
                st_q    <= bus.st;
                size_q  <= bus.size;
                uns_q   <= bus.uns;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                err_q   <= bad_req;
                // Word stores skip the read phase, so their write data is staged now.
                if (!bad_req && bus.st && (bus.size == SZ_WORD)) begin
                    mem_wd_q <= bus.wdata;
                end
            end
            if ((state == LOAD) && !st_q) begin
                rdata_q <= lane_value;
            end
            if (state == RMW_RD) begin
                mem_wd_q <= lane_merged;
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == RESP);
    assign bus.err    = (state == RESP) && err_q;
    assign bus.rdata  = rdata_q;
    assign bus.mem_a  = {addr_q[31:2], 2'b00};
    assign bus.mem_wd = mem_wd_q;
    assign bus.mem_we = (state == WRITE);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random traffic against a
// byte-arithmetic memory model, plus reset-in-WRITE and back-to-back sequences.
module tb_load_store_unit;

    logic clk;
    logic rst;
    lsu_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign bus.mem_rd = mem[bus.mem_a[9:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a[9:2]] = bus.mem_wd;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one request and watch it to completion; inputs are scrambled while
    // busy so the unit must rely on what it captured.
    task automatic run_txn(input logic s, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output int wes, output logic er,
                           output logic [31:0] rd, output logic [31:0] ma);
        lat = 99; wes = 0; er = 1'b0; rd = 32'd0; ma = 32'd0;
        @(negedge clk);
        bus.req = 1'b1; bus.st = s; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_we) wes++;
            if (bus.done) begin
                lat = i; er = bus.err; rd = bus.rdata; ma = bus.mem_a;
                break;
            end
            bus.st = 1'($urandom); bus.size = 2'($urandom); bus.uns = 1'($urandom);
            bus.addr = $urandom; bus.wdata = $urandom;
        end
        bus.req = 1'b0;
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] ofs,
                                             input logic [1:0] sz, input logic u);
        longint unsigned v;
        int bits;
        bits = 8 << sz;
        v = (64'(w) >> (8 * ofs)) & ((64'd1 << bits) - 64'd1);
        if (!u && bits < 32 && v[bits-1]) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] ofs,
                                              input logic [1:0] sz, input logic [31:0] wd);
        longint unsigned mask;
        longint unsigned nw;
        int bits;
        bits = 8 << sz;
        mask = ((64'd1 << bits) - 64'd1) << (8 * ofs);
        nw = (64'(w) & ~mask) | ((64'(wd) << (8 * ofs)) & mask);
        return nw[31:0];
    endfunction

    function automatic bit legal_req(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << sz;
        return (sz != 2'b11) && ((a % nbytes) == 0);
    endfunction

    typedef struct {
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        int          wes;
        logic [31:0] rdata;
        logic [31:0] word;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int lat, wes;
        logic er;
        logic [31:0] rd, ma;
        logic [31:0] ref_mem [0:255];
        logic [31:0] ref_rd;

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 2, 1'b0, 1, 32'h00000000, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        2, 1'b0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h100, 32'h80442211, 2, 1'b0, 1, 32'hDEADBEEF, 32'h80442211};
        tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        2, 1'b0, 0, 32'hFFFFFF80, 32'h80442211};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        2, 1'b0, 0, 32'h00000080, 32'h80442211};
        tbl[5]  = '{1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        2, 1'b0, 0, 32'hFFFF8044, 32'h80442211};
        tbl[6]  = '{1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 2, 1'b0, 1, 32'hFFFF8044, 32'h11223344};
        tbl[7]  = '{1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFFFFAB, 3, 1'b0, 1, 32'hFFFF8044, 32'h1122AB44};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h1234CAFE, 3, 1'b0, 1, 32'hFFFF8044, 32'hCAFEAB44};
        tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h101, 32'h0,        1, 1'b1, 0, 32'hFFFF8044, 32'h80442211};
        tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 1, 1'b1, 0, 32'hFFFF8044, 32'h80442211};
        tbl[11] = '{1'b0, 2'b11, 1'b0, 32'h200, 32'h0,        1, 1'b1, 0, 32'hFFFF8044, 32'hCAFEAB44};
        tbl[12] = '{1'b0, 2'b01, 1'b1, 32'h202, 32'h0,        2, 1'b0, 0, 32'h0000CAFE, 32'hCAFEAB44};

        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        rst = 1'b1;
        bus.req = 1'b0; bus.st = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_done",   {31'd0, bus.done},   32'd0);
        chk("rst_err",    {31'd0, bus.err},    32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_rdata",  bus.rdata,  32'd0);
        chk("rst_mem_a",  bus.mem_a,  32'd0);
        chk("rst_mem_wd", bus.mem_wd, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].st, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, lat, wes, er, rd, ma);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].err});
            chk($sformatf("vec%0d_we_cycles", i), wes, tbl[i].wes);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("vec%0d_mem_word", i), mem[tbl[i].addr[9:2]], tbl[i].word);
        end

        @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            logic [31:0] w;
            w = $urandom;
            mem[k] = w;
            ref_mem[k] = w;
        end
        ref_rd = tbl[12].rdata;
        for (int n = 0; n < 80; n++) begin
            logic s, u;
            logic [1:0] sz;
            logic [31:0] a, wd;
            int e_lat, e_wes;
            logic e_err;
            s = 1'($urandom); u = 1'($urandom); sz = 2'($urandom);
            a = $urandom; wd = $urandom;
            if (!legal_req(sz, a)) begin
                e_lat = 1; e_wes = 0; e_err = 1'b1;
            end else if (!s) begin
                e_lat = 2; e_wes = 0; e_err = 1'b0;
                ref_rd = load_val(ref_mem[a[9:2]], a[1:0], sz, u);
            end else begin
                e_lat = (sz == 2'b10) ? 2 : 3; e_wes = 1; e_err = 1'b0;
                ref_mem[a[9:2]] = store_val(ref_mem[a[9:2]], a[1:0], sz, wd);
            end
            run_txn(s, sz, u, a, wd, lat, wes, er, rd, ma);
            chk($sformatf("rnd%0d_latency", n), lat, e_lat);
            chk($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, e_err});
            chk($sformatf("rnd%0d_we_cycles", n), wes, e_wes);
            chk($sformatf("rnd%0d_rdata", n), rd, ref_rd);
            chk($sformatf("rnd%0d_mem_a", n), ma, {a[31:2], 2'b00});
            chk($sformatf("rnd%0d_mem_word", n), mem[a[9:2]], ref_mem[a[9:2]]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset asserted while a byte store sits in WRITE.
        @(negedge clk);
        mem[8'hC0] = 32'h00000000;
        bus.req = 1'b1; bus.st = 1'b1; bus.size = 2'b00; bus.uns = 1'b0;
        bus.addr = 32'h300; bus.wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("rstw_in_write", {31'd0, bus.mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_busy",   {31'd0, bus.busy},   32'd0);
        chk("rstw_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rstw_done",   {31'd0, bus.done},   32'd0);
        chk("rstw_mem_wd", bus.mem_wd, 32'd0);
        chk("rstw_rdata",  bus.rdata,  32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rstw_mem_word", mem[8'hC0], 32'h00000000);
        rst = 1'b0;

        // req held high across two loads.
        begin
            int accs, dones, first_done, second_acc, low_run, max_low;
            bit prev_busy, switched;
            accs = 0; dones = 0; first_done = -100; second_acc = 0;
            low_run = 0; max_low = 0; prev_busy = 1'b0; switched = 1'b0;
            @(negedge clk);
            mem[8'h40] = 32'h13579BDF;
            mem[8'h80] = 32'h2468ACE0;
            bus.req = 1'b1; bus.st = 1'b0; bus.size = 2'b10; bus.uns = 1'b0; bus.addr = 32'h100;
            for (int i = 0; i < 20 && dones < 2; i++) begin
                @(negedge clk);
                if (bus.busy && !prev_busy) begin
                    accs++;
                    if (accs == 2) second_acc = i;
                end
                if (!bus.busy && accs > 0) low_run++;
                else low_run = 0;
                if (low_run > max_low) max_low = low_run;
                if (accs == 1 && !switched) begin
                    bus.addr = 32'h202; bus.size = 2'b01; bus.uns = 1'b1; switched = 1'b1;
                end
                if (bus.done) begin
                    dones++;
                    if (dones == 1) begin
                        first_done = i;
                        chk("b2b_first_rdata", bus.rdata, 32'h13579BDF);
                    end else begin
                        chk("b2b_second_rdata", bus.rdata, 32'h00002468);
                        bus.req = 1'b0;
                    end
                end
                prev_busy = bus.busy;
            end
            bus.req = 1'b0;
            chk("b2b_done_count", dones, 2);
            chk("b2b_accept_count", accs, 2);
            chk("b2b_accept_gap", second_acc - first_done, 2);
            chk("b2b_max_idle", max_low, 1);
            repeat (3) @(negedge clk);
            chk("b2b_no_extra", {31'd0, bus.busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
